// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples the serial line with the system clock, samples each bit at mid-bit,
// and reports each byte with a one-cycle valid strobe or a one-cycle framing-error strobe.
module uart_rx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Active,
    output logic       o_Frame_Err
);

    localparam logic [9:0] LAST = 10'(CLKS_PER_BIT - 1);
    localparam logic [9:0] HALF = 10'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        CLEANUP    = 3'd4,
        BREAK_WAIT = 3'd5
    } state_t;

    state_t     state_reg, state_next;
    logic       rx_meta_reg, rx_s_reg;
    logic [9:0] count_reg, count_next;
    logic [2:0] index_reg, index_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] byte_reg, byte_next;
    logic       dv_reg, dv_next;
    logic       err_reg, err_next;

    // Synchronizers reset high so a reset never looks like a start edge.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            state_reg   <= IDLE;
            count_reg   <= '0;
            index_reg   <= '0;
            shift_reg   <= '0;
            byte_reg    <= '0;
            dv_reg      <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            rx_meta_reg <= i_RX_Serial;
            rx_s_reg    <= rx_meta_reg;
            state_reg   <= state_next;
            count_reg   <= count_next;
            index_reg   <= index_next;
            shift_reg   <= shift_next;
            byte_reg    <= byte_next;
            dv_reg      <= dv_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        index_next = index_reg;
        shift_next = shift_reg;
        byte_next  = byte_reg;
        dv_next    = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                count_next = '0;
                index_next = '0;
                if (!rx_s_reg) state_next = START;
            end
            START: begin
                if (count_reg == HALF) begin
                    count_next = '0;
                    state_next = rx_s_reg ? IDLE : DATA;
                end else begin
                    count_next = count_reg + 10'd1;
                end
            end
            DATA: begin
                if (count_reg == LAST) begin
                    count_next            = '0;
                    shift_next[index_reg] = rx_s_reg;
                    if (index_reg == 3'd7) begin
                        index_next = '0;
                        state_next = STOP;
                    end else begin
                        index_next = index_reg + 3'd1;
                    end
                end else begin
                    count_next = count_reg + 10'd1;
                end
            end
            STOP: begin
                if (count_reg == LAST) begin
                    count_next = '0;
                    if (rx_s_reg) begin
                        byte_next  = shift_reg;
                        dv_next    = 1'b1;
                        state_next = CLEANUP;
                    end else begin
                        err_next   = 1'b1;
                        state_next = BREAK_WAIT;
                    end
                end else begin
                    count_next = count_reg + 10'd1;
                end
            end
            CLEANUP: begin
                count_next = '0;
                state_next = IDLE;
            end
            // A held-low line must not retrigger, so wait for it to return high.
            BREAK_WAIT: begin
                count_next = '0;
                if (rx_s_reg) state_next = IDLE;
            end
            default: begin
                count_next = '0;
                index_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign o_RX_DV     = dv_reg;
    assign o_Frame_Err = err_reg;
    assign o_RX_Byte   = byte_reg;
    assign o_RX_Active = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-written glitch, reset and break
// sequences; expected events are queued when driven and checked when the receiver reports them.
module tb_uart_rx;

    localparam int CPB = 8;
    localparam int H   = (CPB - 1) / 2;
    localparam int LAT = 3 + H + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       o_RX_Active;
    logic       o_Frame_Err;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (clk),
        .i_Rst_L     (rst_n),
        .i_RX_Serial (rx),
        .o_RX_DV     (o_RX_DV),
        .o_RX_Byte   (o_RX_Byte),
        .o_RX_Active (o_RX_Active),
        .o_Frame_Err (o_Frame_Err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         start_cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_err;
        int         gap_bits;
    } vec_t;
    vec_t vecs[6];

    logic [7:0] last_good = 8'h00;
    logic       post_dv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one line per reported transaction, compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_good <= 8'h00;
            post_dv   <= 1'b0;
        end else begin
            if (post_dv) check("active_low_after_dv", 32'(o_RX_Active), 0);
            post_dv <= o_RX_DV;
            if (o_RX_DV || o_Frame_Err) begin
                $display("event cyc=%0d dv=%0b err=%0b byte=%02h", cyc, o_RX_DV, o_Frame_Err, o_RX_Byte);
                check("dv_err_exclusive", 32'(o_RX_DV && o_Frame_Err), 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got dv=%0b err=%0b byte=%02h expected no event",
                             o_RX_DV, o_Frame_Err, o_RX_Byte);
                end else begin
                    check("event_kind_err", 32'(o_Frame_Err), 32'(sb[0].is_err));
                    if (sb[0].is_err) begin
                        check("byte_held_on_err", 32'(o_RX_Byte), 32'(last_good));
                    end else begin
                        check("rx_byte", 32'(o_RX_Byte), 32'(sb[0].data));
                        last_good <= sb[0].data;
                    end
                    check("latency_in_window",
                          32'(((cyc - sb[0].start_cyc) >= LAT - 2) && ((cyc - sb[0].start_cyc) <= LAT + 2)), 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Drives one frame starting at the current negedge; returns on a negedge at the end of the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic exp_err);
        sb.push_back(exp_t'{exp_err, d, cyc + 1});
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic saw_active;
    logic break_ok;
    logic [7:0] partial;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 2};
        vecs[1] = '{8'h5A, 1'b0, 1'b1, 2};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 0};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 0};
        vecs[4] = '{8'h81, 1'b1, 1'b0, 2};
        vecs[5] = '{8'hC3, 1'b1, 1'b0, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_dv", 32'(o_RX_DV), 0);
        check("reset_byte", 32'(o_RX_Byte), 0);
        check("reset_active", 32'(o_RX_Active), 0);
        check("reset_err", 32'(o_Frame_Err), 0);
        rst_n = 1'b1;
        idle_bits(2);

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].exp_err);
            if (vecs[v].gap_bits > 0) idle_bits(vecs[v].gap_bits);
        end

        // Start-bit glitch: two low cycles must be rejected without any event.
        saw_active = 1'b0;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        for (int i = 0; i < 4 * CPB; i++) begin
            @(negedge clk);
            if (o_RX_Active) saw_active = 1'b1;
        end
        check("glitch_active_seen", 32'(saw_active), 1);
        check("glitch_active_cleared", 32'(o_RX_Active), 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle_bits(2);

        // Reset in the middle of data bit 4; the partial frame must vanish.
        partial = 8'h96;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            repeat (CPB) @(negedge clk);
        end
        rx = partial[4];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        #1;
        check("midreset_dv", 32'(o_RX_DV), 0);
        check("midreset_byte", 32'(o_RX_Byte), 0);
        check("midreset_active", 32'(o_RX_Active), 0);
        check("midreset_err", 32'(o_Frame_Err), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(3);
        send_frame(8'h7E, 1'b1, 1'b0);
        idle_bits(2);

        // Break: 30 bit times low gives one framing error and Active held high.
        sb.push_back(exp_t'{1'b1, 8'h00, cyc + 1});
        rx = 1'b0;
        break_ok = 1'b1;
        for (int i = 0; i < 30 * CPB; i++) begin
            @(negedge clk);
            if (i >= 3 && !o_RX_Active) break_ok = 1'b0;
        end
        check("break_active_held", 32'(break_ok), 1);
        idle_bits(3);
        send_frame(8'h11, 1'b1, 1'b0);
        idle_bits(1);

        for (int i = 0; i < 20 * CPB && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's 8N1 transmitter: 8 data bits, LSB first, one start bit, one stop bit, no parity.
- Oversamples the asynchronous serial line with the system clock, validates the start bit at mid-bit and samples each data bit at mid-bit.
- Presents each received byte with a one-cycle valid strobe and flags framing errors.
- Sits between the board RX pin and the byte-level consumer (command parser / USB bridge logic).

Parameters:
CLKS_PER_BIT, 217, clock cycles per bit = f(i_Clock)/baud; legal range 4..1023 (10-bit counter)

Ports:
i_Clock  in  1  system clock; all logic on rising edge
i_Rst_L  in  1  asynchronous, active-low reset
i_RX_Serial  in  1  asynchronous serial line, idle high
o_RX_DV  out  1  one-cycle pulse: o_RX_Byte holds a newly received valid byte
o_RX_Byte  out  8  last good received byte; held until the next good byte
o_RX_Active  out  1  high from start-bit detection until return to IDLE
o_Frame_Err  out  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset (i_Rst_L low, asynchronous, any state, including mid-frame):
  - o_RX_DV=0, o_RX_Byte=0x00, o_RX_Active=0, o_Frame_Err=0.
  - State=IDLE, bit counter=0, bit index=0.
  - Both synchronizer flops=1.
  - After release, the block waits for a fresh falling edge; a partial frame in progress at reset is discarded.
- Input sync: 2-flop synchronizer on i_RX_Serial. All decisions use the second flop (rx_s). Detection latency is 2 cycles.
- H = (CLKS_PER_BIT-1)/2, integer division. Bit counter is 10 bits and never exceeds CLKS_PER_BIT-1.
- IDLE:
  - counter=0, index=0, o_RX_Active=0.
  - rx_s==0 -> START; counter=0; o_RX_Active=1 from the next cycle.
- START:
  - Increment counter until counter==H.
  - At counter==H: if rx_s==0 -> DATA, counter=0. Otherwise the start is a glitch -> IDLE, with no DV and no error.
- DATA:
  - Increment counter until counter==CLKS_PER_BIT-1.
  - At that cycle: shift register bit[index] <= rx_s; counter=0.
  - index<7 -> index+1, stay in DATA. index==7 -> index=0, go to STOP.
  - All samples therefore fall at mid-bit.
- STOP:
  - Increment counter until counter==CLKS_PER_BIT-1, then sample rx_s.
  - rx_s==1: o_RX_Byte <= shift register; o_RX_DV=1 for exactly one cycle -> CLEANUP.
  - rx_s==0: o_Frame_Err=1 for exactly one cycle; o_RX_Byte unchanged; o_RX_DV stays 0 -> BREAK_WAIT.
- CLEANUP: one cycle; strobes clear -> IDLE. The next start edge can be accepted on the following cycle. Because the stop bit is sampled at mid-bit, back-to-back frames with no idle gap are received.
- BREAK_WAIT: hold with o_RX_Active=1 until rx_s==1, then -> IDLE. A held-low line (break) produces exactly one o_Frame_Err and does not retrigger.
- Undefined state encodings -> IDLE.
- o_RX_DV and o_Frame_Err are never high in the same cycle.
- Latency: o_RX_DV asserts within 2 cycles of 3+H+9*CLKS_PER_BIT cycles after the first clock edge at which i_RX_Serial is low for the start bit.
- Tolerance: correct reception for a baud mismatch of up to ±3% at CLKS_PER_BIT>=16.

Test Plan:
- CLKS_PER_BIT=8: drive 8N1 frame 0xA5 with exact bit timing -> exactly one o_RX_DV pulse, o_RX_Byte=0xA5, o_Frame_Err never high, o_RX_Active low again within 2 cycles of DV.
- Line low for 2 cycles then high (glitch), CLKS_PER_BIT=8 -> o_RX_Active high then low before counter reaches 4 bits' worth of cycles; no DV, no Frame_Err; a following 0x3C frame is received as 0x3C.
- Frame 0x5A with stop bit driven 0, then the line returns high -> one o_Frame_Err pulse, no DV, o_RX_Byte keeps its prior value (e.g. 0xA5).
- Frames 0x00, 0xFF, 0x81 back-to-back with zero idle gap -> three DV pulses in order, bytes 0x00, 0xFF, 0x81.
- Assert i_Rst_L low mid data-bit 4 of a frame, release, then send 0x7E -> all outputs 0 during reset, no DV for the aborted frame, then one DV with 0x7E.
- Hold the line low for 30 bit times (break), then high, then send 0x11 -> exactly one Frame_Err, o_RX_Active high throughout the break, then DV with 0x11.
